// File: rtl/sprite_plot_stage.sv
// +----------------------------------------------------------------------------+
// | sprite_plot_stage                                                          |
// | Realigns sprite pixels with the ROM latency, keys out transparent pixels,  |
// | clips to the screen, and runs full-screen clear sweeps.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sprite_plot_stage #(
    parameter int         ROM_LATENCY  = 1,
    parameter int         SCREEN_W     = 320,
    parameter int         SCREEN_H     = 240,
    parameter logic [2:0] TRANSPARENT  = 3'b111,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clock_all,
    input  logic       reset_all,
    input  logic       clear_req,
    input  logic       draw_active,
    input  logic [8:0] in_x,
    input  logic [7:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       sprite_done,
    output logic       plot,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       busy,
    output logic       stage_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PASS  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [9:0] C_W_LIM      = 10'(SCREEN_W);
    localparam logic [8:0] C_H_LIM      = 9'(SCREEN_H);
    localparam logic [8:0] C_X_LAST     = 9'(SCREEN_W - 1);
    localparam logic [7:0] C_Y_LAST     = 8'(SCREEN_H - 1);
    localparam logic [7:0] C_Y_END      = 8'(SCREEN_H);
    localparam logic [1:0] C_FLUSH_LAST = 2'(ROM_LATENCY);

    state_t     state_q, state_d;
    logic [8:0] clr_x_q, clr_x_d;
    logic [7:0] clr_y_q, clr_y_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       flush_ok_q, flush_ok_d;

    logic [8:0] dl_x_q [ROM_LATENCY];
    logic [8:0] dl_x_d [ROM_LATENCY];
    logic [7:0] dl_y_q [ROM_LATENCY];
    logic [7:0] dl_y_d [ROM_LATENCY];
    logic       dl_v_q [ROM_LATENCY];
    logic       dl_v_d [ROM_LATENCY];

    logic       plot_q, plot_d;
    logic [8:0] vga_x_q, vga_x_d;
    logic [7:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       busy_q, busy_d;
    logic       stage_done_q, stage_done_d;

    logic       push_v;
    logic       pix_ok;
    logic [8:0] dl_x_out;
    logic [7:0] dl_y_out;

    assign dl_x_out = dl_x_q[ROM_LATENCY-1];
    assign dl_y_out = dl_y_q[ROM_LATENCY-1];

    // Delayed coordinates meet the colour the ROM returns for them this cycle.
    assign pix_ok = dl_v_q[ROM_LATENCY-1] && (in_colour != TRANSPARENT)
                    && ({1'b0, dl_x_out} < C_W_LIM) && ({1'b0, dl_y_out} < C_H_LIM);

    always_comb begin
        state_d      = state_q;
        clr_x_d      = clr_x_q;
        clr_y_d      = clr_y_q;
        flush_cnt_d  = flush_cnt_q;
        flush_ok_d   = flush_ok_q;
        plot_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        stage_done_d = 1'b0;
        push_v       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (draw_active) begin
                    state_d = ST_PASS;
                    push_v  = 1'b1;
                end
            end
            ST_CLEAR: begin
                // y reaching SCREEN_H marks the sweep finished, one cycle after the last plot was issued.
                if (clr_y_q == C_Y_END) begin
                    state_d      = ST_IDLE;
                    stage_done_d = 1'b1;
                    clr_x_d      = '0;
                    clr_y_d      = '0;
                end else begin
                    plot_d       = 1'b1;
                    vga_x_d      = clr_x_q;
                    vga_y_d      = clr_y_q;
                    vga_colour_d = CLEAR_COLOUR;
                    if (clr_x_q == C_X_LAST) begin
                        clr_x_d = '0;
                        clr_y_d = (clr_y_q == C_Y_LAST) ? C_Y_END : clr_y_q + 8'd1;
                    end else begin
                        clr_x_d = clr_x_q + 9'd1;
                    end
                end
            end
            ST_PASS: begin
                push_v = draw_active;
                if (pix_ok) begin
                    plot_d       = 1'b1;
                    vga_x_d      = dl_x_out;
                    vga_y_d      = dl_y_out;
                    vga_colour_d = in_colour;
                end
                if (!draw_active) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                    flush_ok_d  = 1'b0;
                end else if (sprite_done) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                    flush_ok_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (pix_ok) begin
                    plot_d       = 1'b1;
                    vga_x_d      = dl_x_out;
                    vga_y_d      = dl_y_out;
                    vga_colour_d = in_colour;
                end
                if (flush_cnt_q == C_FLUSH_LAST) begin
                    state_d      = ST_IDLE;
                    stage_done_d = flush_ok_q;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_comb begin
        dl_x_d[0] = in_x;
        dl_y_d[0] = in_y;
        dl_v_d[0] = push_v;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            dl_x_d[i] = dl_x_q[i-1];
            dl_y_d[i] = dl_y_q[i-1];
            dl_v_d[i] = dl_v_q[i-1];
        end
    end

    always_ff @(posedge clock_all or posedge reset_all) begin
        if (reset_all) begin
            state_q      <= ST_IDLE;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
            flush_cnt_q  <= '0;
            flush_ok_q   <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                dl_x_q[i] <= '0;
                dl_y_q[i] <= '0;
                dl_v_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            clr_x_q      <= clr_x_d;
            clr_y_q      <= clr_y_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_ok_q   <= flush_ok_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            busy_q       <= busy_d;
            stage_done_q <= stage_done_d;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                dl_x_q[i] <= dl_x_d[i];
                dl_y_q[i] <= dl_y_d[i];
                dl_v_q[i] <= dl_v_d[i];
            end
        end
    end

    assign plot       = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign busy       = busy_q;
    assign stage_done = stage_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_plot_stage.sv
// +----------------------------------------------------------------------------+
// | tb_sprite_plot_stage                                                       |
// | Randomized and directed bench for sprite_plot_stage with a pixel-list model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sprite_plot_stage;

    localparam int L = 1;

    logic       clock_all = 1'b0;
    logic       reset_all = 1'b1;
    logic       clear_req = 1'b0;
    logic       draw_active = 1'b0;
    logic [8:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic       sprite_done = 1'b0;
    logic       plot;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       busy;
    logic       stage_done;

    int n_checks = 0;
    int n_fail   = 0;

    int px [64];
    int py [64];
    int pc [64];
    int exp_last_x = 0;
    int exp_last_y = 0;
    int exp_last_c = 0;

    sprite_plot_stage #(
        .ROM_LATENCY (L),
        .SCREEN_W    (320),
        .SCREEN_H    (240),
        .TRANSPARENT (3'b111),
        .CLEAR_COLOUR(3'b000)
    ) u_dut (
        .clock_all  (clock_all),
        .reset_all  (reset_all),
        .clear_req  (clear_req),
        .draw_active(draw_active),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .sprite_done(sprite_done),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .busy       (busy),
        .stage_done (stage_done)
    );

    always #5 clock_all = ~clock_all;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_all);
        #1;
    endtask

    // Pixel k has coordinates in cycle k and colour in cycle k+L; it shows up in cycle k+L+1.
    task automatic run_sprite(input int n, input bit abort_it);
        int j;
        bit exp_plot;
        for (int t = 0; t <= n + L + 3; t++) begin
            if (t > 0) begin
                tick();
                j = t - L - 1;
                exp_plot = (j >= 0) && (j < n) && (pc[j] != 7) && (px[j] < 320) && (py[j] < 240);
                if (exp_plot) begin
                    exp_last_x = px[j];
                    exp_last_y = py[j];
                    exp_last_c = pc[j];
                end
                check("plot", 32'(plot), 32'(exp_plot));
                check("x", 32'(vga_x), 32'(exp_last_x));
                check("y", 32'(vga_y), 32'(exp_last_y));
                check("colour", 32'(vga_colour), 32'(exp_last_c));
                check("stage_done", 32'(stage_done), 32'(!abort_it && (t == n + L + 1)));
                check("busy", 32'(busy), 32'(abort_it ? (t <= n + L + 1) : (t <= n + L)));
            end
            draw_active = (t < n);
            sprite_done = !abort_it && (t == n - 1);
            in_x        = (t < n) ? 9'(px[t]) : 9'($urandom_range(0, 511));
            in_y        = (t < n) ? 8'(py[t]) : 8'($urandom_range(0, 255));
            in_colour   = (t >= L && t - L < n) ? 3'(pc[t - L]) : 3'($urandom_range(0, 7));
        end
        draw_active = 1'b0;
        sprite_done = 1'b0;
    endtask

    // Starts a clear in the current cycle and checks n_plots plots of the raster order.
    task automatic start_clear(input bit with_draw, input int n_plots);
        int i;
        clear_req   = 1'b1;
        draw_active = with_draw;
        in_x        = 9'd40;
        in_y        = 8'd40;
        tick();
        clear_req   = 1'b0;
        draw_active = 1'b0;
        check("clear_first_idle", 32'({plot, busy}), 32'({1'b0, 1'b1}));
        i = 0;
        while (i < n_plots && n_fail < 50) begin
            tick();
            check("clear_pix", 32'({stage_done, plot, vga_x, vga_y, vga_colour}),
                  32'({1'b0, 1'b1, 9'(i % 320), 8'(i / 320), 3'b000}));
            i++;
        end
        exp_last_x = 319;
        exp_last_y = 239;
        exp_last_c = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("idle_quiet", 32'({plot, busy, stage_done}), 32'(0));
        end
    endtask

    task automatic do_reset();
        @(negedge clock_all);
        reset_all = 1'b1;
        #1;
        check("async_plot", 32'(plot), 32'(0));
        check("async_flags", 32'({busy, stage_done}), 32'(0));
        check("async_xyc", 32'({vga_x, vga_y, vga_colour}), 32'(0));
        exp_last_x = 0;
        exp_last_y = 0;
        exp_last_c = 0;
        @(negedge clock_all);
        reset_all = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        bit ab;

        #2;
        check("reset_outputs", 32'({plot, vga_x, vga_y, vga_colour, busy, stage_done}), 32'(0));
        @(negedge clock_all);
        reset_all = 1'b0;
        tick();
        idle_cycles(2);

        // Full clear sweep
        start_clear(1'b0, 76800);
        tick();
        check("clear_done", 32'({stage_done, plot, busy}), 32'({1'b1, 1'b0, 1'b0}));
        tick();
        check("clear_done_pulse", 32'({stage_done, busy}), 32'(0));

        // Latency
        for (int k = 0; k < 3; k++) begin
            px[k] = 10 + k;
            py[k] = 5;
        end
        pc[0] = 4; pc[1] = 2; pc[2] = 1;
        run_sprite(3, 1'b0);

        // Transparency
        pc[1] = 7;
        run_sprite(3, 1'b0);

        // Clipping
        px[0] = 319; py[0] = 239; pc[0] = 1;
        px[1] = 320; py[1] = 239; pc[1] = 2;
        px[2] = 319; py[2] = 240; pc[2] = 3;
        px[3] = 511; py[3] = 0;   pc[3] = 4;
        run_sprite(4, 1'b0);

        // Done on last pixel (52,56), then abort
        for (int k = 0; k < 3; k++) begin
            px[k] = 50 + k;
            py[k] = 56;
            pc[k] = 5 - k;
        end
        run_sprite(3, 1'b0);
        run_sprite(3, 1'b1);

        // Random sprites, biased toward the screen edges and the colour key
        for (int s = 0; s < 40; s++) begin
            n  = $urandom_range(2, 20);
            ab = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < n; k++) begin
                px[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(300, 340) : $urandom_range(0, 511);
                py[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(225, 255) : $urandom_range(0, 255);
                pc[k] = $urandom_range(0, 7);
            end
            run_sprite(n, ab);
        end

        // clear_req beats draw_active; reset at plot 1000
        start_clear(1'b1, 1000);
        do_reset();
        idle_cycles(3);

        // Restart after reset begins again at (0,0)
        start_clear(1'b0, 8);
        do_reset();
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
